// File: rtl/decode_pkg.sv
// decode_pkg: shared opcode classes, format indices, byte masks and bundle types for the decode stage.
package decode_pkg;
  localparam logic [4:0] OP_R      = 5'b01100;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam int FMT_R  = 5;
  localparam int FMT_I  = 4;
  localparam int FMT_S  = 3;
  localparam int FMT_SB = 2;
  localparam int FMT_U  = 1;
  localparam int FMT_UJ = 0;
  localparam logic [3:0] IOB_B    = 4'b0001;
  localparam logic [3:0] IOB_H    = 4'b0011;
  localparam logic [3:0] IOB_W    = 4'b1111;
  localparam logic [3:0] IOB_NONE = 4'b0000;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_t;
  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [3:0] alu_op;
    logic [5:0] fmt;
    logic       load_pc;
    logic       mem_read;
    logic       mem_write;
    logic       mem_sext;
    logic [3:0] iobytes;
    logic       illegal;
  } ctrl_t;
  localparam int CTRL_W = $bits(ctrl_t);
  function automatic logic [3:0] iobytes_of(input logic [1:0] sz);
    return sz == 2'b00 ? IOB_B : sz == 2'b01 ? IOB_H : sz == 2'b10 ? IOB_W : IOB_NONE;
  endfunction
endpackage

// File: rtl/decode_comb.sv
// decode_comb: combinational RV32I word+flags to control bundle and XLEN immediate; DECODE_ILLEGAL_EN enables illegal detection.
module decode_comb
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     word_i,
  input  logic [3:0]      flags_i,
  output ctrl_t           ctrl_o,
  output logic [XLEN-1:0] imm_o
);
  logic [4:0] op;
  logic [2:0] f3;
  logic is_r, is_ia, is_ld, is_st, is_br, is_u, is_j, is_jr, cond, ill, ok;
  logic [31:0] imm32, sh;
  assign op    = word_i[6:2];
  assign f3    = word_i[14:12];
  assign is_r  = op == OP_R;
  assign is_ia = op == OP_IMM;
  assign is_ld = op == OP_LOAD;
  assign is_st = op == OP_STORE;
  assign is_br = op == OP_BRANCH;
  assign is_u  = op == OP_LUI || op == OP_AUIPC;
  assign is_j  = op == OP_JAL;
  assign is_jr = op == OP_JALR;
`ifdef DECODE_ILLEGAL_EN
  assign ill = !(is_r || is_ia || is_ld || is_st || is_br || is_u || is_j || is_jr) ||
               word_i[1:0] != 2'b11 || (is_br && f3[2:1] == 2'b01);
`else
  logic unused_ok;
  assign unused_ok = &{1'b0, word_i[1:0]};
  assign ill = 1'b0;
`endif
  assign ok = !ill;
  // flags are {Z,C,N,V}; unsigned compares come straight from the carry
  assign cond = f3 == 3'b000 ? flags_i[3] : f3 == 3'b001 ? !flags_i[3] :
                f3 == 3'b100 ? flags_i[1] ^ flags_i[0] : f3 == 3'b101 ? !(flags_i[1] ^ flags_i[0]) :
                f3 == 3'b110 ? !flags_i[2] : f3 == 3'b111 ? flags_i[2] : 1'b0;
  assign sh = XLEN == 64 ? {26'b0, word_i[25:20]} : {27'b0, word_i[24:20]};
  assign imm32 = is_u  ? {word_i[31:12], 12'b0} :
                 is_j  ? {{12{word_i[31]}}, word_i[19:12], word_i[20], word_i[30:21], 1'b0} :
                 is_br ? {{20{word_i[31]}}, word_i[7], word_i[30:25], word_i[11:8], 1'b0} :
                 is_st ? {{21{word_i[31]}}, word_i[30:25], word_i[11:7]} :
                 (is_ia && f3[1:0] == 2'b01) ? sh :
                 (is_ia || is_ld || is_jr) ? {{21{word_i[31]}}, word_i[30:20]} : 32'b0;
  assign imm_o = XLEN'($signed(imm32));
  always_comb begin
    ctrl_o             = '0;
    ctrl_o.rs1         = word_i[19:15];
    ctrl_o.rs2         = word_i[24:20];
    ctrl_o.rd          = word_i[11:7];
    ctrl_o.alu_op      = (is_r || is_ia) ? {word_i[30] & (is_r | f3 == 3'b101), f3} : is_br ? 4'b1000 : 4'b0000;
    ctrl_o.fmt[FMT_R]  = ok & is_r;
    ctrl_o.fmt[FMT_I]  = ok & (is_ia | is_ld | is_jr);
    ctrl_o.fmt[FMT_S]  = ok & is_st;
    ctrl_o.fmt[FMT_SB] = ok & is_br;
    ctrl_o.fmt[FMT_U]  = ok & is_u;
    ctrl_o.fmt[FMT_UJ] = ok & is_j;
    ctrl_o.load_pc     = ok & ((is_br & cond) | is_j | is_jr);
    ctrl_o.mem_read    = ok & is_ld;
    ctrl_o.mem_write   = ok & is_st;
    ctrl_o.mem_sext    = ok & is_ld & !f3[2];
    ctrl_o.iobytes     = (ok && (is_ld || is_st)) ? iobytes_of(f3[1:0]) : IOB_NONE;
    ctrl_o.illegal     = ill;
  end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode with a FIFO skid buffer and flush; DECODE_ILLEGAL_EN reports illegal words.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_word,
  input  logic [3:0]      in_flags,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [3:0]      out_alu_op,
  output logic [XLEN-1:0] out_imm,
  output logic [5:0]      out_fmt,
  output logic            out_load_pc,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic            out_mem_sext,
  output logic [3:0]      out_iobytes,
  output logic            out_illegal
);
  localparam int W = CTRL_W + XLEN;
  ctrl_t ctrl, hc;
  logic [XLEN-1:0] imm;
  logic [W-1:0] new_b, head_q, tail_q;
  occ_t st_q, st_d;
  logic accept, pop;
  decode_comb #(.XLEN(XLEN)) u_dec (.word_i(in_word), .flags_i(in_flags), .ctrl_o(ctrl), .imm_o(imm));
  assign new_b     = {ctrl, imm};
  assign out_valid = st_q != EMPTY;
  assign in_ready  = DEPTH == 1 ? (st_q == EMPTY || out_ready) : st_q != TWO;
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign st_d = flush ? EMPTY :
                st_q == EMPTY ? (accept ? ONE : EMPTY) :
                st_q == ONE ? ((accept && !pop) ? TWO : (pop && !accept) ? EMPTY : ONE) :
                (pop ? ONE : TWO);
  // head always drives the outputs; tail only fills while head is blocked
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= EMPTY;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      st_q <= st_d;
      if (!flush) begin
        if (accept && (st_q == EMPTY || pop)) head_q <= new_b;
        else if (pop && st_q == TWO) head_q <= tail_q;
        if (accept && st_q == ONE && !pop) tail_q <= new_b;
      end
    end
  end
  assign hc            = head_q[W-1:XLEN];
  assign out_imm       = head_q[XLEN-1:0];
  assign out_rs1       = hc.rs1;
  assign out_rs2       = hc.rs2;
  assign out_rd        = hc.rd;
  assign out_alu_op    = hc.alu_op;
  assign out_fmt       = hc.fmt;
  assign out_load_pc   = hc.load_pc;
  assign out_mem_read  = hc.mem_read;
  assign out_mem_write = hc.mem_write;
  assign out_mem_sext  = hc.mem_sext;
  assign out_iobytes   = hc.iobytes;
  assign out_illegal   = hc.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed self-checking bench for decode_stage (default DEPTH=2, XLEN=32).
module tb_decode_stage;
  localparam int XLEN = 32;
  logic clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_word;
  logic [3:0] in_flags, out_alu_op, out_iobytes;
  logic [4:0] out_rs1, out_rs2, out_rd;
  logic [XLEN-1:0] out_imm;
  logic [5:0] out_fmt;
  logic out_load_pc, out_mem_read, out_mem_write, out_mem_sext, out_illegal;
  int n_cmp = 0;
  int n_fail = 0;
  decode_stage #(.XLEN(XLEN), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_word(in_word), .in_flags(in_flags), .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_alu_op(out_alu_op),
    .out_imm(out_imm), .out_fmt(out_fmt), .out_load_pc(out_load_pc), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .out_mem_sext(out_mem_sext), .out_iobytes(out_iobytes),
    .out_illegal(out_illegal)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [31:0] w, input logic [3:0] f);
    in_word = w; in_flags = f; in_valid = 1; tick(); in_valid = 0;
  endtask
  task automatic test_reset;
    rst = 1; tick(); tick(); rst = 0;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_fmt !== 6'b0) begin n_fail++; $display("FAIL rst_fmt: got %b want 000000", out_fmt); end
    n_cmp++; if (out_imm !== '0) begin n_fail++; $display("FAIL rst_imm: got %h want 0", out_imm); end
  endtask
  task automatic test_alu;
    out_ready = 1;
    issue(32'h002081B3, 4'h0);
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_fmt !== 6'b100000) begin n_fail++; $display("FAIL add_fmt: got %b want 100000", out_fmt); end
    n_cmp++; if ({out_rs1, out_rs2, out_rd} !== {5'd1, 5'd2, 5'd3}) begin n_fail++; $display("FAIL add_regs: got %0d %0d %0d want 1 2 3", out_rs1, out_rs2, out_rd); end
    n_cmp++; if (out_alu_op !== 4'b0000) begin n_fail++; $display("FAIL add_alu: got %b want 0000", out_alu_op); end
    issue(32'h402081B3, 4'h0);
    n_cmp++; if (out_alu_op !== 4'b1000) begin n_fail++; $display("FAIL sub_alu: got %b want 1000", out_alu_op); end
    issue(32'h4030D093, 4'h0);
    n_cmp++; if (out_alu_op !== 4'b1101) begin n_fail++; $display("FAIL srai_alu: got %b want 1101", out_alu_op); end
    n_cmp++; if (out_imm !== 32'd3) begin n_fail++; $display("FAIL srai_imm: got %h want 3", out_imm); end
    n_cmp++; if (out_fmt !== 6'b010000) begin n_fail++; $display("FAIL srai_fmt: got %b want 010000", out_fmt); end
    issue(32'h12345037, 4'h0);
    n_cmp++; if (out_imm !== 32'h12345000 || out_fmt !== 6'b000010) begin n_fail++; $display("FAIL lui: got imm %h fmt %b want 12345000 000010", out_imm, out_fmt); end
    tick();
  endtask
  task automatic test_branch;
    out_ready = 1;
    issue(32'h00208463, 4'b1000);
    n_cmp++; if (out_load_pc !== 1'b1) begin n_fail++; $display("FAIL beq_taken: got %b want 1", out_load_pc); end
    n_cmp++; if (out_imm !== 32'd8) begin n_fail++; $display("FAIL beq_imm: got %h want 8", out_imm); end
    n_cmp++; if (out_fmt !== 6'b000100 || out_alu_op !== 4'b1000) begin n_fail++; $display("FAIL beq_fmt: got %b %b want 000100 1000", out_fmt, out_alu_op); end
    issue(32'h00208463, 4'b0000);
    n_cmp++; if (out_load_pc !== 1'b0) begin n_fail++; $display("FAIL beq_not_taken: got %b want 0", out_load_pc); end
    issue(32'h0020E463, 4'b0000);
    n_cmp++; if (out_load_pc !== 1'b1) begin n_fail++; $display("FAIL bltu_taken: got %b want 1", out_load_pc); end
    issue(32'h0020E463, 4'b0100);
    n_cmp++; if (out_load_pc !== 1'b0) begin n_fail++; $display("FAIL bltu_not_taken: got %b want 0", out_load_pc); end
    issue(32'h008000EF, 4'b0000);
    n_cmp++; if (out_load_pc !== 1'b1 || out_imm !== 32'd8 || out_fmt !== 6'b000001) begin n_fail++; $display("FAIL jal: got pc %b imm %h fmt %b want 1 8 000001", out_load_pc, out_imm, out_fmt); end
    tick();
  endtask
  task automatic test_load;
    logic [XLEN-1:0] m4;
    m4 = '1;
    m4[1:0] = 2'b00;
    out_ready = 1;
    issue(32'hFFC12283, 4'h0);
    n_cmp++; if ({out_mem_read, out_mem_write, out_mem_sext} !== 3'b101) begin n_fail++; $display("FAIL lw_mem: got %b want 101", {out_mem_read, out_mem_write, out_mem_sext}); end
    n_cmp++; if (out_iobytes !== 4'b1111) begin n_fail++; $display("FAIL lw_iobytes: got %b want 1111", out_iobytes); end
    n_cmp++; if (out_imm !== m4) begin n_fail++; $display("FAIL lw_imm: got %h want %h", out_imm, m4); end
    n_cmp++; if (out_rd !== 5'd5 || out_rs1 !== 5'd2) begin n_fail++; $display("FAIL lw_regs: got %0d %0d want 5 2", out_rd, out_rs1); end
    tick();
  endtask
  task automatic test_illegal;
    out_ready = 1;
    issue(32'h00000000, 4'h0);
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ill_valid: got %b want 1", out_valid); end
`ifdef DECODE_ILLEGAL_EN
    n_cmp++; if (out_illegal !== 1'b1 || out_fmt !== 6'b0 || out_mem_read !== 1'b0) begin n_fail++; $display("FAIL ill_zero: got ill %b fmt %b rd %b want 1 000000 0", out_illegal, out_fmt, out_mem_read); end
`else
    n_cmp++; if (out_illegal !== 1'b0 || out_fmt !== 6'b010000) begin n_fail++; $display("FAIL ill_zero: got ill %b fmt %b want 0 010000", out_illegal, out_fmt); end
`endif
    issue(32'h0000007F, 4'h0);
    n_cmp++; if (out_fmt !== 6'b0 || out_load_pc !== 1'b0 || out_mem_write !== 1'b0) begin n_fail++; $display("FAIL unknown_op: got fmt %b pc %b wr %b want 000000 0 0", out_fmt, out_load_pc, out_mem_write); end
    tick();
  endtask
  task automatic test_backpressure;
    out_ready = 0; in_valid = 1;
    in_word = 32'h002081B3; tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_one: got %b want 1", in_ready); end
    in_word = 32'h00208233; tick();
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_two: got %b want 0", in_ready); end
    in_word = 32'h002082B3; tick();
    n_cmp++; if (out_valid !== 1'b1 || out_rd !== 5'd3) begin n_fail++; $display("FAIL bp_hold: got v %b rd %0d want 1 3", out_valid, out_rd); end
    out_ready = 1; tick();
    n_cmp++; if (out_valid !== 1'b1 || out_rd !== 5'd4) begin n_fail++; $display("FAIL bp_second: got v %b rd %0d want 1 4", out_valid, out_rd); end
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_rd !== 5'd5) begin n_fail++; $display("FAIL bp_third: got v %b rd %0d want 1 5", out_valid, out_rd); end
    in_valid = 0; tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %b want 0", out_valid); end
  endtask
  task automatic test_flush;
    out_ready = 0; in_valid = 1;
    in_word = 32'h002081B3; tick();
    in_word = 32'h00208233; tick();
    flush = 1; in_word = 32'h002082B3; tick();
    flush = 0; in_valid = 0;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_state: got v %b r %b want 0 1", out_valid, in_ready); end
    out_ready = 1; tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_ghost: got %b want 0", out_valid); end
    issue(32'h00208333, 4'h0);
    n_cmp++; if (out_valid !== 1'b1 || out_rd !== 5'd6) begin n_fail++; $display("FAIL flush_after: got v %b rd %0d want 1 6", out_valid, out_rd); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty: got %b want 0", out_valid); end
  endtask
  task automatic test_back_to_back;
    out_ready = 1; in_valid = 1;
    in_word = 32'h002081B3; tick();
    n_cmp++; if (out_rd !== 5'd3 || in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_a: got rd %0d r %b want 3 1", out_rd, in_ready); end
    in_word = 32'h00208233; tick();
    n_cmp++; if (out_rd !== 5'd4 || out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_b: got rd %0d v %b want 4 1", out_rd, out_valid); end
    in_word = 32'h002082B3; tick();
    n_cmp++; if (out_rd !== 5'd5 || out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_c: got rd %0d v %b want 5 1", out_rd, out_valid); end
    in_valid = 0; tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got %b want 0", out_valid); end
  endtask
  initial begin
    rst = 1; flush = 0; in_valid = 0; out_ready = 0; in_word = '0; in_flags = '0;
    test_reset();
    test_alu();
    test_branch();
    test_load();
    test_illegal();
    test_backpressure();
    test_flush();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
